// File: rtl/mapper_banks.sv
// Mode-selectable cartridge bank mapper (NROM, UxROM, CNROM, MMC1).
// Cartridge bus writes are synchronised into the SDRAM clock domain. SDRAM addresses are combinational.
module mapper_banks #(
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned PRG_BANK_BITS = 5,
  parameter int unsigned CHR_BANK_BITS = 5,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 mirror_cfg,
  input  logic                 load_state,
  input  logic [ADDR_BITS-1:0] prg_offset,
  input  logic [ADDR_BITS-1:0] chr_offset,
  input  logic                 m2,
  input  logic                 cpu_rw,
  input  logic                 rom_ce,
  input  logic [14:0]          cpu_addr,
  input  logic [7:0]           cpu_data,
  input  logic [13:0]          ppu_addr,
  output logic [ADDR_BITS-1:0] prg_address,
  output logic [ADDR_BITS-1:0] chr_address,
  output logic                 ciram_a10,
  output logic                 write_ack
);

  localparam int unsigned BusW    = 26;
  localparam logic [4:0]  CtrlRst = 5'h0C;

  typedef enum logic [1:0] {ModeNrom, ModeUxrom, ModeCnrom, ModeMmc1} mode_e;

  // Bus synchroniser: {m2, rw, ce, addr, data} all share one chain.
  logic [BusW-1:0] sync_q [SYNC_STAGES];
  logic            m2_s, rw_s, ce_s;
  logic [14:0]     addr_s;
  logic [7:0]      data_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {m2, cpu_rw, rom_ce, cpu_addr, cpu_data};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {m2_s, rw_s, ce_s, addr_s, data_s} = sync_q[SYNC_STAGES-1];

  logic       cap_rw_q, cap_ce_q;
  logic [1:0] cap_sel_q;
  logic [7:0] cap_data_q;
  logic       m2_prev_q, fall_q;
  logic       m2_fall;

  assign m2_fall = m2_prev_q & ~m2_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_rw_q   <= 1'b1;
      cap_ce_q   <= 1'b1;
      cap_sel_q  <= '0;
      cap_data_q <= '0;
      m2_prev_q  <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      m2_prev_q <= m2_s;
      fall_q    <= m2_fall;
      if (m2_s) begin
        cap_rw_q   <= rw_s;
        cap_ce_q   <= ce_s;
        cap_sel_q  <= addr_s[14:13];
        cap_data_q <= data_s;
      end
    end
  end

  mode_e                    mode_q;
  logic [4:0]               ctrl_q, shift_q, shift_next;
  logic [2:0]               cnt_q;
  logic [1:0]               since_q;
  logic [CHR_BANK_BITS-1:0] chr0_q, chr1_q;
  logic [PRG_BANK_BITS-1:0] prg_q;
  logic                     ack_q;
  logic                     wr_event, accept;

  // NROM has no register, so its writes are neither acked nor counted as accepted.
  assign wr_event   = fall_q & ~cap_rw_q & ~cap_ce_q & ~load_state;
  assign accept     = wr_event && (mode_q != ModeNrom) &&
                      ((mode_q != ModeMmc1) || (since_q == 2'd2));
  assign shift_next = {cap_data_q[0], shift_q[4:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= ModeNrom;
      ctrl_q  <= CtrlRst;
      chr0_q  <= '0;
      chr1_q  <= '0;
      prg_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      since_q <= 2'd2;
      ack_q   <= 1'b0;
    end else if (load_state) begin
      mode_q  <= mode_e'(mode);
      ctrl_q  <= CtrlRst;
      chr0_q  <= '0;
      chr1_q  <= '0;
      prg_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      since_q <= 2'd2;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        since_q <= 2'd0;
      end else if (m2_fall && since_q != 2'd2) begin
        since_q <= since_q + 2'd1;
      end
      if (accept) begin
        case (mode_q)
          ModeUxrom: prg_q <= PRG_BANK_BITS'(cap_data_q);
          ModeCnrom: chr0_q <= CHR_BANK_BITS'(cap_data_q[CHR_BANK_BITS-2:0]);
          ModeMmc1: begin
            if (cap_data_q[7]) begin
              shift_q <= '0;
              cnt_q   <= '0;
              ctrl_q  <= ctrl_q | CtrlRst;
            end else if (cnt_q == 3'd4) begin
              unique case (cap_sel_q)
                2'd0: ctrl_q <= shift_next;
                2'd1: chr0_q <= CHR_BANK_BITS'(shift_next);
                2'd2: chr1_q <= CHR_BANK_BITS'(shift_next);
                2'd3: prg_q  <= PRG_BANK_BITS'(shift_next);
              endcase
              shift_q <= '0;
              cnt_q   <= '0;
            end else begin
              shift_q <= shift_next;
              cnt_q   <= cnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign write_ack = ack_q;

  logic [PRG_BANK_BITS-1:0] pidx;
  logic [CHR_BANK_BITS-1:0] cidx;
  logic                     a14, p12;

  assign a14 = cpu_addr[14];
  assign p12 = ppu_addr[12];

  always_comb begin
    pidx      = {{(PRG_BANK_BITS-1){1'b0}}, a14};
    cidx      = {{(CHR_BANK_BITS-1){1'b0}}, p12};
    ciram_a10 = mirror_cfg ? ppu_addr[10] : ppu_addr[11];
    case (mode_q)
      ModeUxrom: pidx = a14 ? '1 : prg_q;
      ModeCnrom: cidx = {chr0_q[CHR_BANK_BITS-2:0], p12};
      ModeMmc1: begin
        case (ctrl_q[3:2])
          2'd2:    pidx = a14 ? prg_q : '0;
          2'd3:    pidx = a14 ? '1 : prg_q;
          default: pidx = {prg_q[PRG_BANK_BITS-1:1], a14};
        endcase
        if (ctrl_q[4]) cidx = p12 ? chr1_q : chr0_q;
        else           cidx = {chr0_q[CHR_BANK_BITS-1:1], p12};
        unique case (ctrl_q[1:0])
          2'd0: ciram_a10 = 1'b0;
          2'd1: ciram_a10 = 1'b1;
          2'd2: ciram_a10 = ppu_addr[10];
          2'd3: ciram_a10 = ppu_addr[11];
        endcase
      end
      default: ;
    endcase
  end

  // Sums, not ORs: offsets need not be aligned to the bank size.
  assign prg_address = prg_offset + (ADDR_BITS'(pidx) << 14) + ADDR_BITS'(cpu_addr[13:0]);
  assign chr_address = chr_offset + (ADDR_BITS'(cidx) << 12) + ADDR_BITS'(ppu_addr[11:0]);

  logic unused_bits;
  assign unused_bits = ^{addr_s[12:0], ppu_addr[13]};

endmodule

// File: tb/tb_mapper_banks.sv
// Directed bench for mapper_banks: bus-cycle stimulus, expected values queued then checked.
module tb_mapper_banks;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        mirror_cfg, load_state;
  logic [24:0] prg_offset, chr_offset;
  logic        m2, cpu_rw, rom_ce;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [13:0] ppu_addr;
  logic [24:0] prg_address, chr_address;
  logic        ciram_a10, write_ack;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] sb[$];

  mapper_banks dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .mirror_cfg (mirror_cfg),
    .load_state (load_state),
    .prg_offset (prg_offset),
    .chr_offset (chr_offset),
    .m2         (m2),
    .cpu_rw     (cpu_rw),
    .rom_ce     (rom_ce),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .ppu_addr   (ppu_addr),
    .prg_address(prg_address),
    .chr_address(chr_address),
    .ciram_a10  (ciram_a10),
    .write_ack  (write_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = sb.pop_front();
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One CPU bus cycle; counts write_ack pulses and compares with exp_ack.
  task automatic bus_cycle(input logic [14:0] a, input logic [7:0] d, input logic rw,
                           input int exp_ack, input string tag);
    int acks;
    @(negedge clk);
    cpu_addr = a;
    cpu_data = d;
    cpu_rw   = rw;
    rom_ce   = 1'b0;
    m2       = 1'b1;
    repeat (4) @(negedge clk);
    m2   = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (write_ack) acks++;
    end
    cpu_rw = 1'b1;
    rom_ce = 1'b1;
    sb.push_back(32'(exp_ack));
    check(tag, 32'(acks));
  endtask

  // Five serial MMC1 bit writes, each separated by a read cycle so none is back-to-back.
  task automatic mmc1_load(input logic [14:0] a, input logic [4:0] v, input string tag);
    for (int i = 0; i < 5; i++) begin
      bus_cycle(15'h0000, 8'h00, 1'b1, 0, "rd_ack");
      bus_cycle(a, {7'b0, v[i]}, 1'b0, 1, tag);
    end
  endtask

  task automatic probe(input logic [14:0] ca, input logic [13:0] pa, input logic [31:0] e_prg,
                       input logic [31:0] e_chr, input logic e_a10, input string tag);
    cpu_addr = ca;
    ppu_addr = pa;
    sb.push_back(e_prg);
    sb.push_back(e_chr);
    sb.push_back({31'b0, e_a10});
    #1;
    check({tag, "_prg"}, 32'(prg_address));
    check({tag, "_chr"}, 32'(chr_address));
    check({tag, "_a10"}, {31'b0, ciram_a10});
  endtask

  task automatic load(input logic [1:0] m);
    @(negedge clk);
    mode       = m;
    load_state = 1'b1;
    repeat (2) @(negedge clk);
    load_state = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'd0; mirror_cfg = 1'b0; load_state = 1'b0;
    prg_offset = '0; chr_offset = '0;
    m2 = 1'b0; cpu_rw = 1'b1; rom_ce = 1'b1; cpu_addr = '0; cpu_data = '0; ppu_addr = '0;
    repeat (3) @(negedge clk);
    sb.push_back(32'd0);
    check("rst_ack", {31'b0, write_ack});
    probe(15'h4123, 14'h1400, 32'h0000_4123, 32'h0000_1400, 1'b0, "rst_map");
    rst = 1'b0;

    // NROM
    prg_offset = 25'h10_0000; chr_offset = 25'h20_0000; mirror_cfg = 1'b1;
    load(2'd0);
    probe(15'h4123, 14'h0400, 32'h0010_4123, 32'h0020_0400, 1'b1, "nrom_a");
    mirror_cfg = 1'b0;
    probe(15'h0123, 14'h1800, 32'h0010_0123, 32'h0020_1800, 1'b1, "nrom_b");

    // UxROM
    load(2'd1);
    bus_cycle(15'h0000, 8'h03, 1'b0, 1, "ux_ack");
    probe(15'h0010, 14'h0000, 32'h0010_C010, 32'h0020_0000, 1'b0, "ux_lo");
    probe(15'h4010, 14'h1000, 32'h0017_C010, 32'h0020_1000, 1'b0, "ux_hi");
    bus_cycle(15'h0000, 8'h25, 1'b0, 1, "ux_ack2");
    probe(15'h0000, 14'h1000, 32'h0011_4000, 32'h0020_1000, 1'b0, "ux_trunc");
    mode = 2'd2;
    repeat (2) @(negedge clk);
    probe(15'h0000, 14'h1000, 32'h0011_4000, 32'h0020_1000, 1'b0, "ux_frozen");

    // CNROM, then load_state clears the bank and blocks writes
    load(2'd2);
    bus_cycle(15'h0000, 8'h1F, 1'b0, 1, "cn_ack");
    probe(15'h4005, 14'h0005, 32'h0010_4005, 32'h0021_E005, 1'b0, "cn_trunc");
    bus_cycle(15'h0000, 8'h02, 1'b0, 1, "cn_ack2");
    probe(15'h4005, 14'h1005, 32'h0010_4005, 32'h0020_5005, 1'b0, "cn_a");
    @(negedge clk);
    load_state = 1'b1;
    bus_cycle(15'h0000, 8'h05, 1'b0, 0, "load_ack");
    probe(15'h4005, 14'h1005, 32'h0010_4005, 32'h0020_1005, 1'b0, "cn_load");
    load_state = 1'b0;
    probe(15'h0005, 14'h1005, 32'h0010_0005, 32'h0020_1005, 1'b0, "cn_after");

    // MMC1 serial loading and mapping
    load(2'd3);
    probe(15'h0000, 14'h1234, 32'h0010_0000, 32'h0020_1234, 1'b0, "m1_rst");
    probe(15'h4000, 14'h0000, 32'h0017_C000, 32'h0020_0000, 1'b0, "m1_rst_hi");
    mmc1_load(15'h6000, 5'b00101, "m1_wr_prg");
    probe(15'h0000, 14'h0000, 32'h0011_4000, 32'h0020_0000, 1'b0, "m1_prg");
    mmc1_load(15'h0000, 5'b10010, "m1_wr_ctrl");
    mmc1_load(15'h2000, 5'd7, "m1_wr_chr0");
    mmc1_load(15'h4000, 5'd9, "m1_wr_chr1");
    probe(15'h4000, 14'h1234, 32'h0011_4000, 32'h0020_9234, 1'b0, "m1_a");
    probe(15'h0000, 14'h0634, 32'h0011_0000, 32'h0020_7634, 1'b1, "m1_b");

    // Partial shift, reset write, back-to-back write ignored
    bus_cycle(15'h0000, 8'h00, 1'b1, 0, "rd_ack");
    bus_cycle(15'h6000, 8'h01, 1'b0, 1, "m1_part");
    bus_cycle(15'h0000, 8'h00, 1'b1, 0, "rd_ack");
    bus_cycle(15'h6000, 8'h01, 1'b0, 1, "m1_part");
    bus_cycle(15'h0000, 8'h00, 1'b1, 0, "rd_ack");
    bus_cycle(15'h6000, 8'h80, 1'b0, 1, "m1_rstbit");
    bus_cycle(15'h6000, 8'h01, 1'b0, 0, "m1_b2b");
    mmc1_load(15'h6000, 5'b00011, "m1_wr_prg2");
    probe(15'h0000, 14'h1400, 32'h0010_C000, 32'h0020_9400, 1'b1, "m1_c");
    probe(15'h4000, 14'h0000, 32'h0017_C000, 32'h0020_7000, 1'b0, "m1_d");

    // Reset mid-shift
    for (int i = 0; i < 3; i++) begin
      bus_cycle(15'h0000, 8'h00, 1'b1, 0, "rd_ack");
      bus_cycle(15'h6000, 8'h01, 1'b0, 1, "m1_pre_rst");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    probe(15'h4000, 14'h1000, 32'h0010_4000, 32'h0020_1000, 1'b0, "rst_nrom");
    load(2'd3);
    mmc1_load(15'h6000, 5'b00110, "m1_wr_prg3");
    probe(15'h0000, 14'h0000, 32'h0011_8000, 32'h0020_0000, 1'b0, "rst_m1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
